// File: rtl/xor_accum.sv
// Frame XOR accumulator: folds WIDTH-bit words into one XOR word, a parity bit
// and a word count, then holds the result until the consumer acknowledges it.
module xor_accum #(
   parameter  int WIDTH   = 8,
   parameter  int MAX_LEN = 16,
   localparam int CW      = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ack,
   output logic [WIDTH-1:0] out_xor,
   output logic             out_parity,
   output logic [CW-1:0]    out_count,
   output logic [1:0]       dbg_state_o
);

   // Handshakes: a word moves when in_valid && in_ready at a rising edge; the
   // result is held while out_valid is high and retires on the edge with out_ack.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    cnt_inc;
   logic             beat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready = (state_q != HOLD);
   assign beat     = in_valid && in_ready;
   assign cnt_inc  = cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (beat) begin
                  acc_d   = in_data;
                  cnt_d   = CW'(1);
                  state_d = (in_last || MAX_LEN == 1) ? HOLD : ACCUM;
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc_d   = acc_q ^ in_data;
                  cnt_d   = cnt_inc;
                  state_d = (in_last || cnt_inc == MAX_CNT) ? HOLD : ACCUM;
               end
            end
            HOLD: begin
               if (out_ack) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Result is gated so the outputs read zero whenever nothing is held.
   assign out_valid   = (state_q == HOLD);
   assign out_xor     = out_valid ? acc_q : '0;
   assign out_count   = out_valid ? cnt_q : '0;
   assign out_parity  = ^out_xor;
   assign dbg_state_o = state_q;

endmodule

// File: doc/xor_accum.md
# xor_accum

Parametrised XOR accumulator: folds a frame of WIDTH-bit words into one running XOR word plus a single parity bit. Words are accepted through a valid/ready input handshake and the result is held behind a valid/ack output handshake. It generalises the two-input XOR gate to N-word frames of any width and serves as the checksum/parity stage ahead of the lab's display and compare logic.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- MAX_LEN, 16, maximum words per frame; frame auto-closes at this count (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- clear  input  1  synchronous abort of the current frame
- in_valid  input  1  in_data is valid this cycle
- in_data  input  WIDTH  word to fold into the accumulator
- in_last  input  1  qualifies in_valid; marks the final word of the frame
- in_ready  output  1  block accepts a word this cycle
- out_valid  output  1  result is held and valid
- out_ack  input  1  consumer takes the result
- out_xor  output  WIDTH  XOR of all words in the frame
- out_parity  output  1  reduction XOR of out_xor (odd parity of the whole frame)
- out_count  output  CW  number of words in the frame; CW = $clog2(MAX_LEN+1)

## Operation
- A beat is accepted when in_valid && in_ready at a rising clk edge.
- State IDLE (in_ready=1, out_valid=0, acc=0, cnt=0):
  - On an accepted beat: acc←in_data, cnt←1. If in_last or MAX_LEN==1, go to HOLD. Otherwise go to ACCUM.
- State ACCUM (in_ready=1, out_valid=0):
  - On an accepted beat: acc←acc^in_data, cnt←cnt+1. If in_last or cnt+1==MAX_LEN, go to HOLD.
  - With no beat, state is unchanged; idle gaps are allowed.
- State HOLD (in_ready=0, out_valid=1):
  - out_xor=acc, out_parity=^acc, out_count=cnt. All three stay stable until acknowledged.
  - in_valid is ignored.
  - out_ack=1 → IDLE, with acc and cnt cleared.
- in_last on a beat that also reaches MAX_LEN closes the frame once; there is no double close.
- clear=1 in any state → IDLE next edge, acc/cnt cleared, no result produced. clear has priority over a beat and over out_ack in the same cycle.
- out_xor, out_parity and out_count read 0 outside HOLD.
- cnt never exceeds MAX_LEN, so there is no wrap-around.

## Timing
- Reset values: state=IDLE, acc=0, cnt=0, in_ready=1, out_valid=0, out_xor=0, out_parity=0, out_count=0.
- rst assertion mid-frame or in HOLD discards everything immediately, asynchronously. Outputs go to reset values without waiting for clk.
- Latency: out_valid rises on the edge that accepts the closing beat and is visible the following cycle (1 cycle).
- in_ready is a registered function of state and goes low in the cycle out_valid goes high.
- After out_ack, the first new beat can be accepted in the cycle after the ack edge. This gives one bubble cycle; a beat and out_ack in the same cycle are not merged.
- Throughput in ACCUM: one word per clock.
- out_ack outside HOLD has no effect.

## Test plan
- WIDTH=8: beats 0xA5, 0x3C, 0xFF(in_last) back-to-back → one cycle later out_valid=1, out_xor=0x66, out_parity=0, out_count=3. Then out_ack → IDLE, in_ready=1.
- MAX_LEN=4: beats 0x01, 0x02, 0x04, 0x08 with in_last=0 → auto-close, out_xor=0x0F, out_parity=0, out_count=4.
- Single word 0x80 with in_last → out_xor=0x80, out_parity=1, out_count=1. MAX_LEN=1 without in_last gives the identical result.
- Backpressure: hold out_ack=0 for 5 cycles while driving in_valid=1, in_data=0x55 → in_ready=0, outputs frozen at the prior result. Ack → next frame starts clean with acc=0.
- Gaps and clear: 0x11, idle 3 cycles, 0x22, then clear=1 together with in_valid → no out_valid. Next frame 0x33(in_last) → out_xor=0x33, out_count=1.
- Async rst mid-frame after 2 beats, asserted between edges → outputs and in_ready go to reset values immediately. Deassert, then frame 0x0F(in_last) → out_xor=0x0F, out_parity=0, out_count=1.
